// File: rtl/tlb_mem_pkg.sv
// tlb_mem_pkg: shared state encoding and sizing helper for the TLB memory arbiter.
package tlb_mem_pkg;

    typedef enum logic [1:0] {INIT, SERVE, FLUSH} state_t;

    function automatic int cnt_width(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tlb_rr_arb2.sv
// tlb_rr_arb2: two-input round-robin arbiter, one-hot grant, pointer moves on accept.
module tlb_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic pri_b_q, pri_b_d;

    always_comb begin
        grant[0] = valid[0] & (~valid[1] | ~pri_b_q);
        grant[1] = valid[1] & (~valid[0] | pri_b_q);
        pri_b_d  = accept ? grant[0] : pri_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pri_b_q <= 1'b0;
        else     pri_b_q <= pri_b_d;
    end

endmodule

// File: rtl/tlb_mem_arbiter.sv
// tlb_mem_arbiter: initialises/flushes TLB storage and round-robins two refill writers onto its write port.
module tlb_mem_arbiter
    import tlb_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 512,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH_REQ,
    output logic                  FLUSH_DONE,
    output logic                  BUSY,
    input  logic                  WR_A_VALID,
    output logic                  WR_A_READY,
    input  logic [ADDR_WIDTH-1:0] WR_A_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_A_DATA,
    input  logic                  WR_B_VALID,
    output logic                  WR_B_READY,
    input  logic [ADDR_WIDTH-1:0] WR_B_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_B_DATA,
    output logic                  WR_ERR,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  MEM_WREN,
    output logic [ADDR_WIDTH-1:0] MEM_WADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic [ADDR_WIDTH-1:0] MEM_RADDR,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

    localparam int                    CW      = cnt_width(DEPTH);
    localparam logic [CW-1:0]         LAST    = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  walk, serve_en, in_range;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign walk     = state_q != SERVE;
    assign serve_en = !RST && !walk && !FLUSH_REQ;

    tlb_rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .valid  ({WR_B_VALID, WR_A_VALID} & {2{serve_en}}),
        .accept (serve_en & (WR_A_VALID | WR_B_VALID)),
        .grant  (grant)
    );

    always_comb begin
        state_d    = walk ? ((cnt_q == LAST) ? SERVE : state_q) : (FLUSH_REQ ? FLUSH : SERVE);
        cnt_d      = (walk && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
        done_d     = walk && cnt_q == LAST;
        wr_addr    = grant[1] ? WR_B_ADDR : WR_A_ADDR;
        wr_data    = grant[1] ? WR_B_DATA : WR_A_DATA;
        in_range   = {1'b0, wr_addr} < DEPTH_W;
        WR_A_READY = grant[0];
        WR_B_READY = grant[1];
        // Out-of-range writes are still accepted so the requester never stalls.
        WR_ERR     = |grant && !in_range;
        MEM_WREN   = !RST && (walk || (|grant && in_range));
        MEM_WADDR  = walk ? ADDR_WIDTH'(cnt_q) : wr_addr;
        MEM_WDATA  = walk ? FLUSH_VALUE : wr_data;
        BUSY       = RST || walk;
        RD_VALID   = !RST && !walk;
        FLUSH_DONE = !RST && !walk && done_q;
        MEM_RADDR  = RD_ADDR;
        RD_DATA    = MEM_RDATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tlb_mem_arbiter.sv
// tb_tlb_mem_arbiter: directed-vector bench for tlb_mem_arbiter with DEPTH=8 and an async-read memory model.
module tb_tlb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST, FLUSH_REQ, FLUSH_DONE, BUSY;
    logic        WR_A_VALID, WR_A_READY, WR_B_VALID, WR_B_READY, WR_ERR;
    logic [31:0] WR_A_ADDR, WR_A_DATA, WR_B_ADDR, WR_B_DATA;
    logic [31:0] RD_ADDR, RD_DATA, MEM_WADDR, MEM_WDATA, MEM_RADDR, MEM_RDATA;
    logic        RD_VALID, MEM_WREN;
    logic [31:0] mem [8];
    int          nvec = 0;
    int          nerr = 0;

    always #5 CLK = ~CLK;

    tlb_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(8), .FLUSH_VALUE(32'h0)) dut (
        .CLK(CLK), .RST(RST), .FLUSH_REQ(FLUSH_REQ), .FLUSH_DONE(FLUSH_DONE), .BUSY(BUSY),
        .WR_A_VALID(WR_A_VALID), .WR_A_READY(WR_A_READY), .WR_A_ADDR(WR_A_ADDR), .WR_A_DATA(WR_A_DATA),
        .WR_B_VALID(WR_B_VALID), .WR_B_READY(WR_B_READY), .WR_B_ADDR(WR_B_ADDR), .WR_B_DATA(WR_B_DATA),
        .WR_ERR(WR_ERR), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .MEM_WREN(MEM_WREN), .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA)
    );

    always @(posedge CLK) if (MEM_WREN) mem[MEM_WADDR[2:0]] <= MEM_WDATA;
    assign MEM_RDATA = mem[MEM_RADDR[2:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic walk_cycle(input int i);
        #2;
        chk($sformatf("walk_wren%0d", i), MEM_WREN, 1);
        chk($sformatf("walk_addr%0d", i), MEM_WADDR, i);
        chk($sformatf("walk_data%0d", i), MEM_WDATA, 0);
        chk($sformatf("walk_busy%0d", i), BUSY, 1);
        chk($sformatf("walk_rdv%0d", i), RD_VALID, 0);
        chk($sformatf("walk_rdy%0d", i), {WR_A_READY, WR_B_READY}, 0);
        chk($sformatf("walk_done%0d", i), FLUSH_DONE, 0);
        step();
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        RD_ADDR = a;
        #1;
        chk(tag, RD_DATA, exp);
    endtask

    logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hA5A5_A5A5;
        RST = 1; FLUSH_REQ = 0; RD_ADDR = 0;
        WR_A_VALID = 0; WR_A_ADDR = 0; WR_A_DATA = 0;
        WR_B_VALID = 0; WR_B_ADDR = 0; WR_B_DATA = 0;
        step();
        step();
        WR_A_VALID = 1;
        #2;
        chk("rst_wren", MEM_WREN, 0);
        chk("rst_rdy", {WR_A_READY, WR_B_READY}, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_rdv", RD_VALID, 0);
        chk("rst_done", FLUSH_DONE, 0);
        chk("rst_err", WR_ERR, 0);
        step();
        RST = 0; WR_A_VALID = 0;
        for (int i = 0; i < 8; i++) walk_cycle(i);
        #2;
        chk("init_done", FLUSH_DONE, 1);
        chk("init_busy", BUSY, 0);
        chk("init_rdv", RD_VALID, 1);
        chk("init_wren", MEM_WREN, 0);
        for (int i = 0; i < 8; i++) rd($sformatf("init_mem%0d", i), i, 0);
        step();
        #2;
        chk("done_pulse", FLUSH_DONE, 0);
        WR_A_VALID = 1; WR_A_ADDR = 1; WR_A_DATA = 32'h11;
        WR_B_VALID = 1; WR_B_ADDR = 2; WR_B_DATA = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_gnt%0d", i), {WR_B_READY, WR_A_READY}, exp_gnt[i]);
            chk($sformatf("cont_addr%0d", i), MEM_WADDR, exp_gnt[i][0] ? 1 : 2);
            step();
        end
        WR_A_VALID = 0;
        #2;
        chk("b_alone", {WR_B_READY, WR_A_READY}, 2'b10);
        step();
        WR_A_VALID = 1;
        #2;
        chk("both_a_first", {WR_B_READY, WR_A_READY}, 2'b01);
        step();
        WR_B_VALID = 0; WR_A_ADDR = 3; WR_A_DATA = 32'hDEADBEEF;
        #1;
        rd("same_cycle_old", 3, 0);
        chk("single_rdy", WR_A_READY, 1);
        chk("single_wren", MEM_WREN, 1);
        chk("single_waddr", MEM_WADDR, 3);
        chk("single_wdata", MEM_WDATA, 32'hDEADBEEF);
        chk("single_err", WR_ERR, 0);
        step();
        WR_A_VALID = 0;
        rd("single_rd", 3, 32'hDEADBEEF);
        rd("cont_rd1", 1, 32'h11);
        rd("cont_rd2", 2, 32'h22);
        WR_A_VALID = 1; WR_A_ADDR = 5; WR_A_DATA = 32'h55; FLUSH_REQ = 1;
        #1;
        chk("flush_a_rdy", WR_A_READY, 0);
        chk("flush_req_wren", MEM_WREN, 0);
        step();
        FLUSH_REQ = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) rd("walk_rd_old", 3, 32'hDEADBEEF);
            walk_cycle(i);
        end
        #2;
        chk("flush_done", FLUSH_DONE, 1);
        chk("flush_a_gnt", WR_A_READY, 1);
        chk("flush_a_waddr", MEM_WADDR, 5);
        rd("flush_rd3", 3, 0);
        step();
        WR_A_VALID = 0;
        rd("post_flush_rd5", 5, 32'h55);
        WR_B_VALID = 1; WR_B_ADDR = 8; WR_B_DATA = 32'h99;
        #1;
        chk("oor_rdy", WR_B_READY, 1);
        chk("oor_err", WR_ERR, 1);
        chk("oor_wren", MEM_WREN, 0);
        step();
        WR_B_VALID = 0;
        #1;
        chk("oor_err_pulse", WR_ERR, 0);
        rd("oor_mem0", 0, 0);
        FLUSH_REQ = 1;
        step();
        FLUSH_REQ = 0;
        for (int i = 0; i < 5; i++) walk_cycle(i);
        RST = 1;
        #2;
        chk("midrst_wren", MEM_WREN, 0);
        chk("midrst_busy", BUSY, 1);
        step();
        RST = 0;
        for (int i = 0; i < 8; i++) begin
            FLUSH_REQ = (i >= 2 && i <= 6);
            walk_cycle(i);
        end
        FLUSH_REQ = 0;
        #2;
        chk("midrst_done", FLUSH_DONE, 1);
        chk("midrst_busy_end", BUSY, 0);
        step();
        #2;
        chk("no_second_walk_busy", BUSY, 0);
        chk("no_second_walk_wren", MEM_WREN, 0);
        chk("no_second_walk_done", FLUSH_DONE, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
